// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int num_slices(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

  function automatic int idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_N     = num_slices(16, 4);
  localparam int DEFAULT_IDX_W = idx_bits(DEFAULT_N);

endpackage

// File: rtl/cla_slice.sv
// One CHUNK-bit carry-lookahead slice; every carry is a flat sum of
// generate/propagate products rather than a rippled chain.
module cla_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK:0]   c;
  logic             gen_term;
  logic             prop;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in
  always_comb begin
    c        = '0;
    gen_term = 1'b0;
    prop     = 1'b0;
    c[0]     = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      gen_term = g[i];
      prop     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gen_term = gen_term | (prop & g[j]);
        prop     = prop & p[j];
      end
      c[i+1] = gen_term | (prop & c_in);
    end
  end

  assign s        = p ^ c[CHUNK-1:0];
  assign c_out    = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes operands LSB-first, one CHUNK-bit
// lookahead slice per clock, with valid/ready handshakes on both sides.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);

  localparam int N     = num_slices(WIDTH, CHUNK);
  localparam int IDX_W = idx_bits(N);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $fatal(1, "chunked_adder: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, slice_s;
  logic             slice_c_out, slice_c_msb;

  cla_slice #(.CHUNK(CHUNK)) u_slice (
    .a        (a_chunk),
    .b        (b_chunk),
    .c_in     (carry_q),
    .s        (slice_s),
    .c_out    (slice_c_out),
    .c_msb_in (slice_c_msb)
  );

  // b is stored pre-inverted for subtract so the slice only ever adds
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    a_chunk = '0;
    b_chunk = '0;

    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = c_in ^ sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            s_d[i*CHUNK +: CHUNK] = slice_s;
          end
        end
        carry_d = slice_c_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          c_out_d = slice_c_out;
          ovf_d   = slice_c_msb ^ slice_c_out;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed and model-checked bench for chunked_adder in three geometries:
// 16/4 (index 0), 16/16 (index 1) and 32/8 (index 2).
module tb_chunked_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        c_in, sub;
  logic [2:0]  in_valid, out_ready;
  logic [2:0]  in_ready, out_valid, c_out, ovf;
  logic [15:0] s0, s1;
  logic [31:0] s2;

  int checks = 0;
  int errors = 0;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .sub(sub),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .s(s0), .c_out(c_out[0]), .overflow(ovf[0]));

  chunked_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .sub(sub),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .s(s1), .c_out(c_out[1]), .overflow(ovf[1]));

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .s(s2), .c_out(c_out[2]), .overflow(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact (WIDTH+1)-bit sum of a, ~b (if sub) and the adjusted carry
  function automatic void ref_model(input int width, input logic [31:0] ra, input logic [31:0] rb,
                                    input logic rc, input logic rsub,
                                    output logic [31:0] es, output logic ec, output logic eov);
    logic [31:0] mask, bp;
    logic [32:0] sum;
    mask = (width == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    bp   = (rb ^ {32{rsub}}) & mask;
    sum  = {1'b0, ra & mask} + {1'b0, bp} + {32'b0, rc ^ rsub};
    es   = sum[31:0] & mask;
    ec   = sum[width];
    eov  = (ra[width-1] == bp[width-1]) && (es[width-1] != ra[width-1]);
  endfunction

  function automatic logic [31:0] cur_s(input int which);
    if (which == 2) return s2;
    if (which == 1) return {16'h0, s1};
    return {16'h0, s0};
  endfunction

  // Accept one operation, wait (bounded) for out_valid, sample, then hand off
  task automatic run_op(input int which, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tc, input logic tsub,
                        output logic [31:0] os, output logic oc, output logic oov, output int lat);
    a = ta; b = tb_v; c_in = tc; sub = tsub;
    in_valid[which] = 1'b1;
    @(posedge clk); #1;
    in_valid[which] = 1'b0;
    lat = 0;
    while (out_valid[which] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    os  = cur_s(which);
    oc  = c_out[which];
    oov = ovf[which];
    out_ready[which] = 1'b1;
    @(posedge clk); #1;
    out_ready[which] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 3'b111) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 111", in_ready); end
    checks++; if (out_valid !== 3'b000) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 000", out_valid); end
    checks++; if (s0 !== 16'h0 || s1 !== 16'h0 || s2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_s: got %h %h %h expected 0", s0, s1, s2); end
    checks++; if (c_out !== 3'b000) begin errors++; $display("[TB] FAIL reset_c_out: got %b expected 000", c_out); end
    checks++; if (ovf !== 3'b000) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 000", ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Hand-computed vectors for the 16/4 geometry: {a, b, c_in, sub, s, c_out, ovf}
  task automatic test_add_sub();
    logic [15:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        vsb[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] xs [4] = '{16'h0000, 16'h8001, 16'hFFFE, 16'h7FFF};
    logic        xc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        xo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] os;
    logic        oc, oov;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(0, {16'h0, va[i]}, {16'h0, vb[i]}, vc[i], vsb[i], os, oc, oov, lat);
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL vec%0d_latency: got %0d expected 4", i, lat); end
      checks++; if (os[15:0] !== xs[i]) begin errors++; $display("[TB] FAIL vec%0d_s: got %h expected %h", i, os[15:0], xs[i]); end
      checks++; if (oc !== xc[i]) begin errors++; $display("[TB] FAIL vec%0d_c_out: got %b expected %b", i, oc, xc[i]); end
      checks++; if (oov !== xo[i]) begin errors++; $display("[TB] FAIL vec%0d_overflow: got %b expected %b", i, oov, xo[i]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    a = 32'h1234; b = 32'h0F0F; c_in = 1'b0; sub = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (out_valid[0] !== 1'b1 && lat < 64) begin
      a = 32'hAAAA; b = 32'h5555;
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      a = (i % 2 == 0) ? 32'hFFFF : 32'h0001;
      b = (i % 2 == 0) ? 32'h7FFF : 32'h8000;
      sub = i[0];
      @(posedge clk); #1;
      checks++; if (s0 !== 16'h2143 || c_out[0] !== 1'b0 || ovf[0] !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_hold_%0d: got s=%h c=%b ov=%b expected s=2143 c=0 ov=0", i, s0, c_out[0], ovf[0]); end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_%0d: got %b expected 0", i, in_ready[0]); end
      checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid_%0d: got %b expected 1", i, out_valid[0]); end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_out_valid: got %b expected 0", out_valid[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready: got %b expected 1", in_ready[0]); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] os;
    logic        oc, oov;
    int          lat;
    a = 32'h1111; b = 32'h2222; c_in = 1'b0; sub = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (s0 !== 16'h0) begin errors++; $display("[TB] FAIL midrun_s: got %h expected 0000", s0); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL midrun_in_ready: got %b expected 1", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b0 || c_out[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_flags: got ov=%b c=%b ovf=%b expected 0 0 0", out_valid[0], c_out[0], ovf[0]); end
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 32'h1234, 32'h1111, 1'b0, 1'b0, os, oc, oov, lat);
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 4", lat); end
    checks++; if (os[15:0] !== 16'h2345) begin errors++; $display("[TB] FAIL post_reset_s: got %h expected 2345", os[15:0]); end
    checks++; if (oc !== 1'b0 || oov !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_flags: got c=%b ov=%b expected 0 0", oc, oov); end
  endtask

  // Model-checked vectors on the 16/16 and 32/8 instances, corners first
  task automatic test_geometries();
    logic [31:0] os, es, ta, tbv;
    logic        oc, oov, ec, eov, tc, ts;
    int          lat, width, want_lat;
    for (int w = 1; w <= 2; w++) begin
      width    = (w == 2) ? 32 : 16;
      want_lat = (w == 2) ? 4 : 1;
      for (int i = 0; i < 8; i++) begin
        case (i)
          0:       begin ta = 32'h7FFF_FFFF; tbv = 32'h0000_0001; tc = 1'b0; ts = 1'b0; end
          1:       begin ta = 32'h8000_8000; tbv = 32'h0000_0001; tc = 1'b1; ts = 1'b1; end
          2:       begin ta = 32'hFFFF_FFFF; tbv = 32'hFFFF_FFFF; tc = 1'b1; ts = 1'b0; end
          default: begin ta = $urandom; tbv = $urandom; tc = 1'($urandom); ts = 1'($urandom); end
        endcase
        if (width == 16) begin ta[31:16] = 16'h0; tbv[31:16] = 16'h0; end
        ref_model(width, ta, tbv, tc, ts, es, ec, eov);
        run_op(w, ta, tbv, tc, ts, os, oc, oov, lat);
        checks++; if (lat != want_lat) begin errors++; $display("[TB] FAIL geo%0d_%0d_latency: got %0d expected %0d", w, i, lat, want_lat); end
        checks++; if (os !== es) begin errors++; $display("[TB] FAIL geo%0d_%0d_s: got %h expected %h", w, i, os, es); end
        checks++; if (oc !== ec) begin errors++; $display("[TB] FAIL geo%0d_%0d_c_out: got %b expected %b", w, i, oc, ec); end
        checks++; if (oov !== eov) begin errors++; $display("[TB] FAIL geo%0d_%0d_overflow: got %b expected %b", w, i, oov, eov); end
      end
    end
  endtask

  initial begin
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    in_valid = '0; out_ready = '0;
    test_reset();
    test_add_sub();
    test_backpressure();
    test_reset_mid_run();
    test_geometries();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
